serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_fa_bit.sv | 13 +
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed for a counter that must be able to hold the value width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// rtl/serial_fa_bit.sv - combinational one-bit full adder cell
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder; SERIAL_ADDER_SUB_EN adds a sub port
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nx;
    logic [WIDTH-1:0] b_load;
    logic             carry;
    logic             carry_load;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as A + ~B + 1: invert B on load and force the carry in.
    assign b_load     = sub ? ~B : B;
    assign carry_load = sub ? 1'b1 : Cin;
`else
    assign b_load     = B;
    assign carry_load = Cin;
`endif

    serial_fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        sum_nx            = sum_r >> 1;
        sum_nx[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    sum_r <= sum_nx;
                    cnt   <= cnt + 1'b1;
                    // cout is captured on the last bit so it is valid alongside done.
                    if (cnt == LAST) begin
                        cout  <= fa_co;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sum = sum_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] sum;
    logic         cout, busy, done;

    logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
    logic sum1, cout1, busy1, done1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .sum(sum), .cout(cout), .busy(busy), .done(done)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
        logic [W-1:0] nb;
        nb = ~b;
        if (sb) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sb, input string name);
        logic [W:0] exp;
        exp = model(a, b, ci, sb);
        A = a; B = b; Cin = ci; sub = sb; start = 1'b1;
        step();
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
        end
        for (int i = 1; i <= W; i++) begin
            step();
            A = W'($urandom); B = W'($urandom);
            n_cmp++;
            if (done !== (i == W) || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s shift%0d: done=%b busy=%b required done=%b busy=1",
                         name, i, done, busy, (i == W));
            end
        end
        n_cmp++;
        if ({cout, sum} !== exp) begin
            n_bad++;
            $display("FAIL %s result: got %h required %h", name, {cout, sum}, exp);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
            n_bad++;
            $display("FAIL %s idle: done=%b busy=%b res=%h required 0 0 %h",
                     name, done, busy, {cout, sum}, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (sum !== '0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            sum1 !== 1'b0 || cout1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: sum=%h cout=%b busy=%b done=%b w1=%b%b%b%b required all 0",
                     sum, cout, busy, done, sum1, cout1, busy1, done1);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_01");
        run_op(8'h5A, 8'h33, 1'b1, 1'b0, "5a_plus_33_c1");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "max");
        run_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic sb;
`ifdef SERIAL_ADDER_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), sb, "random");
            if ($urandom_range(0, 2) == 0) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [50];
        logic [W-1:0] ob [50];
        logic         oc [50];
        int next_done = W;
        int n_done = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            oa[cyc] = W'($urandom); ob[cyc] = W'($urandom); oc[cyc] = 1'($urandom);
            A = oa[cyc]; B = ob[cyc]; Cin = oc[cyc]; sub = 1'b0; start = 1'b1;
            step();
            if (done === 1'b1) begin
                n_done++;
                n_cmp++;
                if (cyc != next_done) begin
                    n_bad++;
                    $display("FAIL b2b spacing: done at %0d required %0d", cyc, next_done);
                end else begin
                    n_cmp++;
                    if ({cout, sum} !== model(oa[cyc-W], ob[cyc-W], oc[cyc-W], 1'b0)) begin
                        n_bad++;
                        $display("FAIL b2b result at %0d: got %h required %h", cyc, {cout, sum},
                                 model(oa[cyc-W], ob[cyc-W], oc[cyc-W], 1'b0));
                    end
                end
                next_done = cyc + W + 2;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (n_done != 5) begin
            n_bad++;
            $display("FAIL b2b count: got %0d dones required 5", n_done);
        end
        for (int i = 0; i < W + 2; i++) step();
    endtask

    task automatic test_reset_abort();
        bit seen_done = 0;
        A = 8'hFF; B = 8'h00; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (sum !== '0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort: sum=%h cout=%b busy=%b done=%b required all 0",
                     sum, cout, busy, done);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done !== 1'b0) seen_done = 1;
        end
        n_cmp++;
        if (seen_done) begin
            n_bad++;
            $display("FAIL abort_no_done: done pulsed=1 required 0");
        end
        run_op(8'h5A, 8'h33, 1'b1, 1'b0, "after_abort");
    endtask

    task automatic test_width1();
        for (int v = 0; v < 8; v++) begin
            logic [1:0] exp;
            logic [2:0] bits;
            bits = 3'(v);
            a1 = bits[2]; b1 = bits[1]; cin1 = bits[0]; sub1 = 1'b0;
            exp = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            a1 = ~a1; b1 = ~b1;
            n_cmp++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_bad++;
                $display("FAIL w1 accept v=%0d: busy=%b done=%b required 1 0", v, busy1, done1);
            end
            step();
            n_cmp++;
            if (done1 !== 1'b1 || {cout1, sum1} !== exp) begin
                n_bad++;
                $display("FAIL w1 result v=%0d: done=%b res=%b required 1 %b",
                         v, done1, {cout1, sum1}, exp);
            end
            step();
            n_cmp++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                n_bad++;
                $display("FAIL w1 idle v=%0d: done=%b busy=%b required 0 0", v, done1, busy1);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        run_op(8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");
        run_op(8'h00, 8'h01, 1'b1, 1'b1, "sub_00_01");
        run_op(8'h80, 8'h80, 1'b0, 1'b1, "sub_equal");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_width1();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
